prefetch_redirect_ctrl: RTL and testbench
=========================================

// Module: prefetch_redirect_ctrl
// PURPOSE
//  Sequences instruction prefetch: owns the live fetch CS:IP, issues word fetches on the memory
//  bus, pushes returned bytes into the prefetch FIFO, and applies atomic CS:IP redirects
//  (the synchronized update pulse from the execution unit). Guarantees no byte fetched from
//  the old stream reaches the FIFO after a redirect, including fetches already in flight.
// PARAMETERS
//  FIFO_DEPTH  6        prefetch FIFO capacity in bytes; fetch issued only with >=2 bytes free
//  RESET_CS    16'hffff CS loaded at reset
//  RESET_IP    16'h0000 IP loaded at reset
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   asynchronous active-low reset
//  redirect      in   1   one-cycle pulse: load new_cs/new_ip as fetch pointer
//  new_cs        in   16  redirect target CS, valid with redirect
//  new_ip        in   16  redirect target IP, valid with redirect
//  fifo_count    in   3   current FIFO occupancy in bytes (0..FIFO_DEPTH)
//  fetch_req     out  1   bus request; held until fetch_ack
//  fetch_addr    out  19  word address [19:1] of physical (CS<<4)+IP
//  fetch_ack     in   1   one-cycle: fetch_rdata valid, request complete
//  fetch_rdata   in   16  returned word
//  fifo_wr_en    out  1   push fifo_wr_data into FIFO this cycle
//  fifo_wr_two   out  1   with fifo_wr_en: 1 = push both bytes (low first), 0 = push [15:8] only
//  fifo_wr_data  out  16  data to push
//  fifo_flush    out  1   one-cycle FIFO clear
//  redirect_busy out  1   redirect accepted but first new-stream fetch not yet issued
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, cs=RESET_CS, ip=RESET_IP, all outputs 0.
//  Physical address = {cs,4'b0} + {4'b0,ip}, truncated to 20 bits (wraps at 1MB).
//  States: IDLE, WAIT, DRAIN.
//  IDLE: if fifo_count <= FIFO_DEPTH-2 and no redirect and fifo_flush=0 this cycle,
//   register fetch_req=1 and fetch_addr -> WAIT next cycle. fetch_addr stable while req high.
//  WAIT: on fetch_ack (no redirect): fetch_req=0 next cycle; fifo_wr_en=1 next cycle,
//   fifo_wr_two=~ip[0], fifo_wr_data=fetch_rdata; ip += ip[0] ? 1 : 2 (16-bit wrap, cs
//   unchanged) -> IDLE.
//  Redirect rules (any state): cs/ip <= new_cs/new_ip at the edge redirect is sampled;
//   fifo_flush=1 the following cycle only; redirect_busy=1 from that cycle until the
//   first fetch_req of the new stream is raised.
//   - IDLE + redirect: no fetch that cycle; earliest new fetch_req is 2 cycles later
//     (cycle after the flush pulse).
//   - WAIT + redirect without ack: -> DRAIN; fetch_req stays 1, address unchanged.
//   - WAIT + redirect with same-cycle ack: returned data discarded (fifo_wr_en stays 0),
//     ip not incremented, -> IDLE.
//   - DRAIN: on fetch_ack discard data, fetch_req=0 -> IDLE. Further redirect in DRAIN
//     overwrites target and produces another flush pulse; state stays DRAIN.
//  fifo_wr_en and fifo_flush never asserted in the same cycle; no stale-stream write ever
//   occurs after fifo_flush.
//  Room check uses fifo_count as presented; with FIFO_DEPTH=6 a fetch is issued at count<=4.
//  Only one fetch outstanding at any time; fetch_req never drops without fetch_ack.
//  Reset mid-fetch: fetch_req drops immediately; a later stray fetch_ack while IDLE ignored.
// TESTING
//  Reset release, fifo_count=0 -> fetch_req=1, fetch_addr=19'h7fff8; ack 16'h1234 ->
//   fifo_wr_en, fifo_wr_two=1, data 16'h1234, next fetch_addr=19'h7fff9.
//  Redirect cs=16'h0000 ip=16'h0101 in IDLE -> fifo_flush 1 cycle later, then fetch_addr=
//   19'h00080 with fifo_wr_two=0 on ack; following fetch_addr=19'h00081.
//  Redirect while WAIT, ack 3 cycles later -> fetch_req held, no fifo_wr_en, one flush pulse,
//   next request at new target; two redirects in DRAIN -> two flush pulses, last target used.
//  Redirect coincident with fetch_ack -> no FIFO write, new target fetched next.
//  fifo_count=5 -> no fetch_req; drop to 4 -> fetch_req next cycle.
//  cs=16'hffff ip=16'hfffe fetch -> addr wraps 20-bit; ip wraps to 16'h0000, cs unchanged.

Source files
------------

// File: rtl/prefetch_redirect_ctrl.sv
// Prefetch sequencer: owns the fetch CS:IP, issues one word fetch at a time and
// applies atomic CS:IP redirects so that no old-stream byte reaches the FIFO after a flush.
module prefetch_redirect_ctrl #(
   parameter int          FIFO_DEPTH = 6,
   parameter logic [15:0] RESET_CS   = 16'hffff,
   parameter logic [15:0] RESET_IP   = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        redirect,
   input  logic [15:0] new_cs,
   input  logic [15:0] new_ip,
   input  logic [2:0]  fifo_count,
   output logic        fetch_req,
   output logic [18:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [15:0] fetch_rdata,
   output logic        fifo_wr_en,
   output logic        fifo_wr_two,
   output logic [15:0] fifo_wr_data,
   output logic        fifo_flush,
   output logic        redirect_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [2:0] ROOM_MAX = 3'(FIFO_DEPTH - 2);

   state_t      r_state;
   logic [15:0] r_cs;
   logic [15:0] r_ip;
   logic        r_req;
   logic [18:0] r_addr;
   logic        r_wr_en;
   logic        r_wr_two;
   logic [15:0] r_wr_data;
   logic        r_flush;
   logic        r_busy;

   state_t      w_state_nxt;
   logic [15:0] w_cs_nxt;
   logic [15:0] w_ip_nxt;
   logic        w_req_nxt;
   logic [18:0] w_addr_nxt;
   logic        w_wr_en_nxt;
   logic        w_wr_two_nxt;
   logic [15:0] w_wr_data_nxt;
   logic        w_flush_nxt;
   logic        w_busy_nxt;

   logic        w_room;
   logic [18:0] w_word_addr;
   logic [15:0] w_ip_inc;

   assign w_room      = (fifo_count <= ROOM_MAX);
   // Word address of (CS<<4)+IP: IP bit 0 never carries, so it drops out of the sum.
   assign w_word_addr = {r_cs, 3'b000} + {4'b0000, r_ip[15:1]};
   assign w_ip_inc    = r_ip + (r_ip[0] ? 16'd1 : 16'd2);

   always_comb begin
      w_state_nxt   = r_state;
      w_cs_nxt      = r_cs;
      w_ip_nxt      = r_ip;
      w_req_nxt     = r_req;
      w_addr_nxt    = r_addr;
      w_wr_en_nxt   = 1'b0;
      w_wr_two_nxt  = r_wr_two;
      w_wr_data_nxt = r_wr_data;
      w_flush_nxt   = redirect;
      w_busy_nxt    = r_busy;

      case (r_state)
         ST_IDLE: begin
            // The flush cycle itself must not launch a fetch.
            if (!redirect && !r_flush && w_room) begin
               w_req_nxt   = 1'b1;
               w_addr_nxt  = w_word_addr;
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (fetch_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
               if (!redirect) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_two_nxt  = ~r_ip[0];
                  w_wr_data_nxt = fetch_rdata;
                  w_ip_nxt      = w_ip_inc;
               end
            end else if (redirect) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // In-flight fetch belongs to the old stream: complete it and drop the data.
            if (fetch_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (redirect) begin
         w_cs_nxt   = new_cs;
         w_ip_nxt   = new_ip;
         w_busy_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_cs      <= RESET_CS;
         r_ip      <= RESET_IP;
         r_req     <= 1'b0;
         r_addr    <= '0;
         r_wr_en   <= 1'b0;
         r_wr_two  <= 1'b0;
         r_wr_data <= '0;
         r_flush   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cs      <= w_cs_nxt;
         r_ip      <= w_ip_nxt;
         r_req     <= w_req_nxt;
         r_addr    <= w_addr_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_two  <= w_wr_two_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_flush   <= w_flush_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign fetch_req     = r_req;
   assign fetch_addr    = r_addr;
   assign fifo_wr_en    = r_wr_en;
   assign fifo_wr_two   = r_wr_two;
   assign fifo_wr_data  = r_wr_data;
   assign fifo_flush    = r_flush;
   assign redirect_busy = r_busy;

endmodule

// File: tb/tb_prefetch_redirect_ctrl.sv
// Bench for prefetch_redirect_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model (outstanding fetch, stale flag, stream pointer).
module tb_prefetch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        redirect;
   logic [15:0] new_cs;
   logic [15:0] new_ip;
   logic [2:0]  fifo_count;
   logic        fetch_req;
   logic [18:0] fetch_addr;
   logic        fetch_ack;
   logic [15:0] fetch_rdata;
   logic        fifo_wr_en;
   logic        fifo_wr_two;
   logic [15:0] fifo_wr_data;
   logic        fifo_flush;
   logic        redirect_busy;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [15:0] m_cs, m_ip;
   logic        m_out, m_stale;
   logic        e_req, e_wr, e_two, e_flush, e_busy;
   logic [18:0] e_addr;
   logic [15:0] e_data;

   always #5 clk = ~clk;

   prefetch_redirect_ctrl dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .redirect      (redirect),
      .new_cs        (new_cs),
      .new_ip        (new_ip),
      .fifo_count    (fifo_count),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_ack     (fetch_ack),
      .fetch_rdata   (fetch_rdata),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wr_two   (fifo_wr_two),
      .fifo_wr_data  (fifo_wr_data),
      .fifo_flush    (fifo_flush),
      .redirect_busy (redirect_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
      int p;
      p = (int'(cs) * 16 + int'(ip)) % 1048576;
      return 19'(p / 2);
   endfunction

   task automatic model_reset();
      m_cs = 16'hffff; m_ip = 16'h0000;
      m_out = 1'b0; m_stale = 1'b0;
      e_req = 1'b0; e_wr = 1'b0; e_two = 1'b0; e_flush = 1'b0; e_busy = 1'b0;
      e_addr = '0; e_data = '0;
   endtask

   // One clock of the stream rules, applied to the inputs present at the edge.
   task automatic model_step();
      logic was_out, was_flush;
      if (!reset_n) begin
         model_reset();
         return;
      end
      was_out   = m_out;
      was_flush = e_flush;
      e_flush   = redirect;
      e_wr      = 1'b0;
      if (was_out && fetch_ack) begin
         m_out = 1'b0;
         if (!m_stale && !redirect) begin
            e_wr   = 1'b1;
            e_two  = ~m_ip[0];
            e_data = fetch_rdata;
            m_ip   = 16'((int'(m_ip) + (m_ip[0] ? 1 : 2)) % 65536);
         end
      end else if (was_out && redirect) begin
         m_stale = 1'b1;
      end
      if (!was_out && !redirect && !was_flush && fifo_count <= 3'd4) begin
         m_out   = 1'b1;
         m_stale = 1'b0;
         e_addr  = word_addr(m_cs, m_ip);
         e_busy  = 1'b0;
      end
      if (redirect) begin
         m_cs   = new_cs;
         m_ip   = new_ip;
         e_busy = 1'b1;
      end
      e_req = m_out;
   endtask

   task automatic check_all();
      chk("req", 32'(fetch_req), 32'(e_req));
      if (e_req) chk("addr", 32'(fetch_addr), 32'(e_addr));
      chk("wr_en", 32'(fifo_wr_en), 32'(e_wr));
      if (e_wr) begin
         chk("wr_two", 32'(fifo_wr_two), 32'(e_two));
         chk("wr_data", 32'(fifo_wr_data), 32'(e_data));
      end
      chk("flush", 32'(fifo_flush), 32'(e_flush));
      chk("busy", 32'(redirect_busy), 32'(e_busy));
      chk("flush_vs_wr", 32'(fifo_wr_en & fifo_flush), 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic rd, input logic [15:0] cs, input logic [15:0] ip,
                        input logic [2:0] cnt, input logic ack, input logic [15:0] data);
      redirect    = rd;
      new_cs      = cs;
      new_ip      = ip;
      fifo_count  = cnt;
      fetch_ack   = ack;
      fetch_rdata = data;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      model_reset();
      tick();
      tick();
      chk("rst_req", 32'(fetch_req), 32'h0);
      chk("rst_flush", 32'(fifo_flush), 32'h0);

      // Reset release and first fetch
      reset_n = 1'b1;
      tick();
      chk("t1_req", 32'(fetch_req), 32'h1);
      chk("t1_addr", 32'(fetch_addr), 32'h7fff8);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h1234);
      tick();
      chk("t1_wr", 32'(fifo_wr_en), 32'h1);
      chk("t1_two", 32'(fifo_wr_two), 32'h1);
      chk("t1_data", 32'(fifo_wr_data), 32'h1234);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t1_next", 32'(fetch_addr), 32'h7fff9);
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b1, 16'haaaa);
      tick();
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b0, 16'h0);
      tick();

      // Redirect in IDLE to odd IP
      drive(1'b1, 16'h0000, 16'h0101, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t2_flush", 32'(fifo_flush), 32'h1);
      chk("t2_busy", 32'(redirect_busy), 32'h1);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t2_noreq", 32'(fetch_req), 32'h0);
      tick();
      chk("t2_addr", 32'(fetch_addr), 32'h00080);
      chk("t2_busy0", 32'(redirect_busy), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'habcd);
      tick();
      chk("t2_two", 32'(fifo_wr_two), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t2_next", 32'(fetch_addr), 32'h00081);

      // Two redirects while the fetch is in flight, ack later
      drive(1'b1, 16'h5000, 16'h0000, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t3_hold", 32'(fetch_addr), 32'h00081);
      drive(1'b1, 16'h1234, 16'h0010, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t3_flush2", 32'(fifo_flush), 32'h1);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t3_req_held", 32'(fetch_req), 32'h1);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'hdead);
      tick();
      chk("t3_nowr", 32'(fifo_wr_en), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t3_addr", 32'(fetch_addr), 32'h091a8);

      // Redirect coincident with ack
      drive(1'b1, 16'h0000, 16'h0200, 3'd0, 1'b1, 16'h5555);
      tick();
      chk("t4_nowr", 32'(fifo_wr_en), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      tick();
      chk("t4_addr", 32'(fetch_addr), 32'h00100);

      // Room threshold
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b1, 16'h1111);
      tick();
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b0, 16'h0);
      tick();
      tick();
      chk("t5_full", 32'(fetch_req), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 3'd4, 1'b0, 16'h0);
      tick();
      chk("t5_req", 32'(fetch_req), 32'h1);
      chk("t5_addr", 32'(fetch_addr), 32'h00101);

      // 1MB wrap and IP wrap
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b1, 16'h2222);
      tick();
      drive(1'b1, 16'hffff, 16'hfffe, 3'd5, 1'b0, 16'h0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b0, 16'h0);
      tick();
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t6_addr", 32'(fetch_addr), 32'h07ff7);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0f0f);
      tick();
      chk("t6_two", 32'(fifo_wr_two), 32'h1);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t6_wrap", 32'(fetch_addr), 32'h7fff8);

      // Reset in the middle of a fetch, then a stray ack
      reset_n = 1'b0;
      #1;
      chk("t7_req_drop", 32'(fetch_req), 32'h0);
      model_reset();
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b0, 16'h0);
      tick();
      reset_n = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 3'd5, 1'b1, 16'h7777);
      tick();
      chk("t7_stray", 32'(fifo_wr_en), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0);
      tick();
      chk("t7_refetch", 32'(fetch_addr), 32'h7fff8);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 9) == 0), 16'($urandom), 16'($urandom),
               3'($urandom_range(0, 6)),
               m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0),
               16'($urandom));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
